// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and address helper for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

   typedef enum logic [0:0] {
      FETCH_RUN   = 1'b0,
      FETCH_FLUSH = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory request/response, redirect and decode handshake bundle of the fetch stage.
interface instruction_fetch_if;
   import fetch_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, word} entries with single-cycle flush.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [2*XLEN-1:0] push_data,
   input  logic              pop,
   output logic [2*XLEN-1:0] head_data,
   output logic [CW-1:0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [2*XLEN-1:0] mem_q [DEPTH];
   logic [2*XLEN-1:0] mem_d [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   // A push into a full buffer is only taken when a pop frees the slot in the same cycle.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Credit-based instruction fetch: issues word fetches, buffers responses with their pc,
// and drains stale responses after a redirect before refetching.
module instruction_fetch import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   instruction_fetch_if.master bus
);

   localparam int              CW           = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);
   localparam logic [0:0]      ST_RUN       = FETCH_RUN;
   localparam logic [0:0]      ST_FLUSH     = FETCH_FLUSH;

   logic [0:0]        state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]     fifo_count;
   logic [2*XLEN-1:0] fifo_head;
   logic [XLEN-1:0]   oldest_pc;
   logic              req_valid, req_fire, resp_fire, inst_valid;
   logic              fifo_push, fifo_pop;

   // In RUN every in-flight request is contiguous and ends just below pc_q,
   // so the pc of the oldest one is recovered arithmetically.
   always_comb begin
      req_valid = !rst && (state_q == ST_RUN) &&
                  (({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT_LIMIT);
      req_fire  = req_valid && bus.imem_req_ready;
      resp_fire = bus.imem_resp_valid && !rst;
      inst_valid = !rst && (fifo_count != '0);
      oldest_pc = pc_q - XLEN'({outstanding_q, 2'b00});
      fifo_push = resp_fire && (state_q == ST_RUN) && !bus.redirect_valid;
      fifo_pop  = inst_valid && bus.inst_ready && !bus.redirect_valid;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      if (req_fire) begin
         pc_d = pc_q + XLEN'(INST_BYTES);
      end
      if (state_q == ST_RUN) begin
         outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
      end else begin
         drop_cnt_d = drop_cnt_q - CW'(resp_fire);
         if (drop_cnt_d == '0) begin
            state_d = ST_RUN;
         end
      end
      // Everything still in flight at a redirect, including this cycle's request, is stale.
      if (bus.redirect_valid) begin
         pc_d = word_align(bus.redirect_pc);
         if (state_q == ST_RUN) begin
            drop_cnt_d = outstanding_d;
         end
         outstanding_d = '0;
         state_d       = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect_valid),
      .push      (fifo_push),
      .push_data ({oldest_pc, bus.imem_resp_data}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid;
   assign bus.instruction    = inst_valid ? fifo_head[XLEN-1:0] : NOP;
   assign bus.inst_pc        = fifo_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench: queue-based fetch model compared every cycle, plus directed
// scenarios with hand-computed addresses.
`timescale 1ns/1ps
module tb_instruction_fetch;
   import fetch_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   instruction_fetch_if bus();
   instruction_fetch_if bus2();

   instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hBAD0_BAD0;
   endfunction

   // Memory: in-order responses, fixed latency, cleared by reset.
   int          lat    = 1;
   int          edge_n = 0;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];

   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         mem_addr_q.delete();
         mem_due_q.delete();
      end else begin
         if (bus.imem_resp_valid && mem_addr_q.size() > 0) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_addr_q.push_back(bus.imem_req_addr);
            mem_due_q.push_back(edge_n + lat);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= edge_n + 1) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = mem_word(mem_addr_q[0]);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = '0;
      end
   end

   // Transfer logs of the main DUT for literal checks.
   logic [31:0] acc_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_ins_log[$];

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.imem_req_valid && bus.imem_req_ready) acc_log.push_back(bus.imem_req_addr);
         if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            pop_pc_log.push_back(bus.inst_pc);
            pop_ins_log.push_back(bus.instruction);
         end
      end
   end

   // Second DUT: latency-1 memory, logs accepted addresses.
   logic        d2_acc = 1'b0;
   logic [31:0] d2_log[$];

   always @(posedge clk) begin
      d2_acc = !rst && bus2.imem_req_valid && bus2.imem_req_ready;
      if (d2_acc) d2_log.push_back(bus2.imem_req_addr);
   end

   always @(negedge clk) begin
      bus2.imem_resp_valid = d2_acc;
      bus2.imem_resp_data  = NOP;
   end

   // Reference model: good requests in flight, count of stale ones, decode buffer.
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_inflight[$];
   int          m_stale = 0;
   logic [63:0] m_fifo[$];

   function automatic bit exp_req_valid();
      return !rst && (m_stale == 0) && ((m_inflight.size() + m_fifo.size()) < DEPTH);
   endfunction

   always @(posedge clk) begin
      bit          acc;
      bit          pop;
      logic [31:0] rpc;
      if (rst) begin
         m_pc = 32'h0;
         m_inflight.delete();
         m_stale = 0;
         m_fifo.delete();
      end else begin
         acc = exp_req_valid() && bus.imem_req_ready;
         pop = (m_fifo.size() > 0) && bus.inst_ready;
         if (pop && !bus.redirect_valid) void'(m_fifo.pop_front());
         if (bus.imem_resp_valid) begin
            if (m_stale > 0) begin
               m_stale--;
            end else if (m_inflight.size() > 0) begin
               rpc = m_inflight.pop_front();
               if (!bus.redirect_valid) m_fifo.push_back({rpc, mem_word(rpc)});
            end
         end
         if (acc) begin
            m_inflight.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
         if (bus.redirect_valid) begin
            m_stale = m_stale + m_inflight.size();
            m_inflight.delete();
            m_fifo.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check_output("req_valid", 32'(bus.imem_req_valid), 32'(exp_req_valid()));
      if (exp_req_valid()) check_output("req_addr", bus.imem_req_addr, m_pc);
      check_output("inst_valid", 32'(bus.inst_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         check_output("inst_pc", bus.inst_pc, m_fifo[0][63:32]);
         check_output("instruction", bus.instruction, m_fifo[0][31:0]);
      end
   end

   task automatic apply_stimulus(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      acc_log.delete();
      pop_pc_log.delete();
      pop_ins_log.delete();
      rst = 1'b0;
      #1;
      check_output("post_reset_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_output("post_reset_req_addr", bus.imem_req_addr, 32'h0000_0000);
   endtask

   task automatic clear_logs();
      acc_log.delete();
      pop_pc_log.delete();
      pop_ins_log.delete();
   endtask

   task automatic wait_first_pop(input string name);
      int n;
      n = 0;
      while (pop_pc_log.size() == 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output(name, 32'(pop_pc_log.size() > 0), 32'd1);
   endtask

   initial begin
      bit found;
      bus.imem_req_ready  = 1'b1;
      bus.inst_ready      = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus2.imem_req_ready = 1'b1;
      bus2.inst_ready     = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc    = '0;

      // Streaming at latency 1
      lat = 1;
      do_reset();
      repeat (12) @(negedge clk);
      check_output("s1_acc0", q_at(acc_log, 0), 32'h0);
      check_output("s1_acc1", q_at(acc_log, 1), 32'h4);
      check_output("s1_acc2", q_at(acc_log, 2), 32'h8);
      check_output("s1_pc0", q_at(pop_pc_log, 0), 32'h0);
      check_output("s1_pc1", q_at(pop_pc_log, 1), 32'h4);
      check_output("s1_pc2", q_at(pop_pc_log, 2), 32'h8);
      check_output("s1_ins0", q_at(pop_ins_log, 0), 32'h5A5A_0013);
      check_output("s1_ins2", q_at(pop_ins_log, 2), 32'h5A5A_001B);
      check_output("wrap_acc0", q_at(d2_log, 0), 32'hFFFF_FFF8);
      check_output("wrap_acc1", q_at(d2_log, 1), 32'hFFFF_FFFC);
      check_output("wrap_acc2", q_at(d2_log, 2), 32'h0000_0000);

      // Decode stalled: credit stops at two requests
      do_reset();
      bus.inst_ready = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check_output("s2_acc_count", 32'(acc_log.size()), 32'd2);
      check_output("s2_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_output("s2_inst_pc", bus.inst_pc, 32'h0);
      bus.inst_ready = 1'b1;
      repeat (6) @(negedge clk);
      check_output("s2_resume_addr", q_at(acc_log, 2), 32'h8);

      // Redirect with nothing outstanding
      do_reset();
      bus.inst_ready = 1'b0;
      repeat (8) @(negedge clk);
      apply_stimulus(32'h0000_0040);
      clear_logs();
      #1;
      check_output("s2b_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_output("s2b_req_addr", bus.imem_req_addr, 32'h0000_0040);
      bus.inst_ready = 1'b1;
      wait_first_pop("s2b_pop_seen");
      check_output("s2b_first_pc", q_at(pop_pc_log, 0), 32'h0000_0040);

      // Latency 3, two stale requests dropped
      lat = 3;
      do_reset();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (acc_log.size() >= 2) found = 1;
      end
      check_output("s3_two_acc", 32'(found), 32'd1);
      apply_stimulus(32'h0000_0100);
      clear_logs();
      #1;
      check_output("s3_flush_req_valid", 32'(bus.imem_req_valid), 32'd0);
      wait_first_pop("s3_pop_seen");
      check_output("s3_first_acc", q_at(acc_log, 0), 32'h0000_0100);
      check_output("s3_first_pc", q_at(pop_pc_log, 0), 32'h0000_0100);
      check_output("s3_first_ins", q_at(pop_ins_log, 0), 32'h5A5A_0113);

      // Redirect coinciding with a response and a pop
      lat = 1;
      do_reset();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (bus.imem_resp_valid && bus.inst_valid) found = 1;
      end
      check_output("s4_coincide_seen", 32'(found), 32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0300;
      @(posedge clk);
      #1;
      check_output("s4_inst_valid_after", 32'(bus.inst_valid), 32'd0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      clear_logs();
      wait_first_pop("s4_pop_seen");
      check_output("s4_first_pc", q_at(pop_pc_log, 0), 32'h0000_0300);

      // Second redirect while flushing
      lat = 3;
      do_reset();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (acc_log.size() >= 2) found = 1;
      end
      check_output("s5_two_acc", 32'(found), 32'd1);
      apply_stimulus(32'h0000_0100);
      apply_stimulus(32'h0000_0200);
      clear_logs();
      wait_first_pop("s5_pop_seen");
      check_output("s5_first_acc", q_at(acc_log, 0), 32'h0000_0200);
      check_output("s5_first_pc", q_at(pop_pc_log, 0), 32'h0000_0200);

      // Mixed backpressure with redirects, one carrying low address bits
      lat = 2;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 41) clear_logs();
         bus.imem_req_ready = (i % 3) != 0;
         bus.inst_ready     = (i % 4) != 1;
         bus.redirect_valid = (i == 17) || (i == 40);
         bus.redirect_pc    = (i == 17) ? 32'h0000_1000 : 32'h0000_2003;
      end
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      repeat (10) @(negedge clk);
      check_output("s6_aligned_acc", q_at(acc_log, 0), 32'h0000_2000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
